// File: rtl/pc_gen_multi.sv
// Pre-IF PC generator: prioritised redirects, pending-redirect latch, multiple outstanding
// ROM fetches tracked in a PC FIFO, and suppression of responses that predate a redirect.
module pc_gen_multi #(
    parameter int unsigned         ADDR_W          = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC        = '0,
    parameter int unsigned         FETCH_BYTES     = 4,
    parameter int unsigned         MAX_OUTSTANDING = 2,
    parameter int unsigned         NUM_REDIRECT    = 2,
    localparam int unsigned        CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REDIRECT-1:0]        redirect_valid,
    input  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_addr,
    input  logic                           fence_flush,
    input  logic                           jtag_halt_flag_i,
    input  logic                           clint_hold_flag,
    input  logic                           allow_in_if,
    output logic                           rom_req,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic                           mem_addr_ok,
    input  logic                           mem_data_ok,
    output logic                           resp_valid,
    output logic [ADDR_W-1:0]              resp_pc,
    output logic [CNT_W-1:0]               outstanding
);

    localparam int unsigned      PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_v_q, pend_v_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  kill_q, kill_d;
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [MAX_OUTSTANDING-1:0][ADDR_W-1:0] fifo_q;

    logic              redir;
    logic [ADDR_W-1:0] redir_addr;
    logic              hold;
    logic              acc;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Scan from the lowest-priority source so the lowest set index wins.
    always_comb begin
        redir      = 1'b0;
        redir_addr = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                redir      = 1'b1;
                redir_addr = redirect_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign hold     = fence_flush | jtag_halt_flag_i | clint_hold_flag;
    assign rom_addr = redir ? redir_addr : (pend_v_q ? pend_addr_q : pc_q);
    assign rom_req  = rst_n && !hold && allow_in_if && (out_q < MAX_CNT);
    assign acc      = rom_req && mem_addr_ok;
    // A data beat with nothing outstanding has no owner and is ignored.
    assign pop      = mem_data_ok && (out_q != '0);

    assign resp_pc     = fifo_q[rd_q];
    assign resp_valid  = rst_n && pop && (kill_q == '0) && !redir;
    assign outstanding = out_q;

    always_comb begin
        pc_d        = pc_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        if (acc) begin
            pc_d     = rom_addr + ADDR_W'(FETCH_BYTES);
            pend_v_d = 1'b0;
        end else if (redir) begin
            pend_v_d    = 1'b1;
            pend_addr_d = redir_addr;
        end
    end

    // Everything still in flight at a redirect is stale; a request accepted in the
    // redirect cycle already carries the new target and is not counted.
    always_comb begin
        out_d  = out_q + CNT_W'(acc) - CNT_W'(pop);
        kill_d = kill_q;
        if (redir) begin
            kill_d = out_q - CNT_W'(pop);
        end else if (pop && (kill_q != '0)) begin
            kill_d = kill_q - 1'b1;
        end
    end

    always_comb begin
        wr_d = acc ? ptr_inc(wr_q) : wr_q;
        rd_d = pop ? ptr_inc(rd_q) : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            out_q       <= '0;
            kill_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fifo_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            out_q       <= out_d;
            kill_q      <= kill_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            if (acc) begin
                fifo_q[wr_q] <= rom_addr;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_multi.sv
// Bench for pc_gen_multi: directed scenarios plus random traffic, checked every cycle
// against a queue model where each in-flight fetch carries its own live/stale flag.
module tb_pc_gen_multi;

    localparam int MAXO = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  redirect_valid;
    logic [63:0] redirect_addr;
    logic        fence_flush, jtag_halt_flag_i, clint_hold_flag, allow_in_if;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        mem_addr_ok, mem_data_ok;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic [1:0]  outstanding;

    pc_gen_multi #(
        .ADDR_W(32), .RESET_PC(32'h0), .FETCH_BYTES(4),
        .MAX_OUTSTANDING(MAXO), .NUM_REDIRECT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .fence_flush(fence_flush), .jtag_halt_flag_i(jtag_halt_flag_i),
        .clint_hold_flag(clint_hold_flag), .allow_in_if(allow_in_if),
        .rom_req(rom_req), .rom_addr(rom_addr),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .resp_valid(resp_valid), .resp_pc(resp_pc), .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: fetch sequence state and in-flight list.
    logic [31:0] m_pc, m_pa;
    bit          m_pv;
    logic [31:0] qpc[$];
    bit          qlv[$];

    bit          e_redir, e_req, e_acc, e_pop, e_rv;
    logic [31:0] e_raddr, e_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_pv = 0;
        m_pa = 32'h0;
        qpc.delete();
        qlv.delete();
    endtask

    task automatic eval();
        bit found;
        #1;
        found   = 0;
        e_raddr = 32'h0;
        for (int i = 0; i < 2; i++) begin
            if (!found && redirect_valid[i]) begin
                found   = 1;
                e_raddr = redirect_addr[i*32 +: 32];
            end
        end
        e_redir = found;
        e_addr  = e_redir ? e_raddr : (m_pv ? m_pa : m_pc);
        e_req   = rst_n && !(fence_flush || jtag_halt_flag_i || clint_hold_flag)
                  && allow_in_if && (qpc.size() < MAXO);
        e_acc   = e_req && mem_addr_ok;
        e_pop   = mem_data_ok && (qpc.size() > 0);
        e_rv    = rst_n && e_pop && qlv[0] && !e_redir;
        chk("rom_req", 64'(rom_req), 64'(e_req));
        chk("rom_addr", 64'(rom_addr), 64'(e_addr));
        chk("resp_valid", 64'(resp_valid), 64'(e_rv));
        chk("outstanding", 64'(outstanding), 64'(qpc.size()));
        if (e_pop) chk("resp_pc", 64'(resp_pc), 64'(qpc[0]));
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (e_pop) begin
                void'(qpc.pop_front());
                void'(qlv.pop_front());
            end
            if (e_redir) foreach (qlv[i]) qlv[i] = 0;
            if (e_acc) begin
                qpc.push_back(e_addr);
                qlv.push_back(1);
                m_pc = e_addr + 32'd4;
                m_pv = 0;
            end else if (e_redir) begin
                m_pv = 1;
                m_pa = e_raddr;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    task automatic idle();
        redirect_valid   = 2'b00;
        redirect_addr    = 64'h0;
        fence_flush      = 0;
        jtag_halt_flag_i = 0;
        clint_hold_flag  = 0;
        allow_in_if      = 1;
        mem_addr_ok      = 0;
        mem_data_ok      = 0;
    endtask

    task automatic drain();
        idle();
        mem_data_ok = 1;
        for (int i = 0; i < MAXO; i++) cyc();
        mem_data_ok = 0;
    endtask

    task automatic redirect0(input logic [31:0] a);
        redirect_valid = 2'b01;
        redirect_addr  = {32'h0, a};
    endtask

    initial begin
        int n_acc;
        idle();
        rst_n = 0;
        allow_in_if = 1;
        mem_addr_ok = 1;
        mem_data_ok = 1;
        model_reset();
        @(negedge clk);
        // Reset state: no request even with everything ready.
        eval();
        chk("rst_req", 64'(rom_req), 64'h0);
        chk("rst_out", 64'(outstanding), 64'h0);
        adv();
        cyc();
        rst_n = 1;

        // T1: sequential fetch, ROM always ready, one-cycle data.
        for (int i = 0; i < 8; i++) begin
            eval();
            if (i < 3) chk("t1_addr", 64'(rom_addr), 64'(4 * i));
            if (i == 1) chk("t1_resp", {31'h0, resp_valid, resp_pc}, {31'h0, 1'b1, 32'h0});
            adv();
        end

        // T2: redirect while the ROM stalls the address phase.
        idle();
        redirect0(32'h100);
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("t2_hold", {31'h0, rom_req, rom_addr}, {31'h0, 1'b1, 32'h100});
            adv();
            redirect_valid = 2'b00;
        end
        mem_addr_ok = 1;
        cyc();
        mem_addr_ok = 0;
        eval();
        chk("t2_next", 64'(rom_addr), 64'h104);
        adv();
        drain();

        // T3: two in flight, redirect to 0x200; both old responses are stale.
        idle();
        mem_addr_ok = 1;
        cyc();
        cyc();
        redirect0(32'h200);
        eval();
        chk("t3_full", {31'h0, rom_req, rom_addr}, {31'h0, 1'b0, 32'h200});
        adv();
        idle();
        mem_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("t3_stale", 64'(resp_valid), 64'h0);
            adv();
        end
        idle();
        mem_addr_ok = 1;
        eval();
        chk("t3_refetch", 64'(rom_addr), 64'h200);
        adv();
        idle();
        mem_data_ok = 1;
        eval();
        chk("t3_live", {31'h0, resp_valid, resp_pc}, {31'h0, 1'b1, 32'h200});
        adv();

        // T4: both sources at once; source 0 wins.
        idle();
        redirect_valid = 2'b11;
        redirect_addr  = {32'h400, 32'h300};
        mem_addr_ok    = 1;
        eval();
        chk("t4_prio", 64'(rom_addr), 64'h300);
        adv();
        idle();
        eval();
        chk("t4_next", 64'(rom_addr), 64'h304);
        adv();
        drain();

        // T5: address phase ready, data withheld: stop at the outstanding limit.
        idle();
        mem_addr_ok = 1;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            eval();
            if (rom_req && mem_addr_ok) n_acc++;
            adv();
        end
        chk("t5_accepts", 64'(n_acc), 64'd2);
        mem_data_ok = 1;
        eval();
        chk("t5_no_refill", 64'(rom_req), 64'h0);
        adv();
        mem_data_ok = 0;
        eval();
        chk("t5_refill", 64'(rom_req), 64'h1);
        adv();
        drain();

        // T6: redirect during a fence hold is fetched once the hold drops.
        idle();
        fence_flush = 1;
        mem_addr_ok = 1;
        redirect0(32'h500);
        cyc();
        redirect_valid = 2'b00;
        for (int i = 0; i < 3; i++) cyc();
        fence_flush = 0;
        eval();
        chk("t6_release", {31'h0, rom_req, rom_addr}, {31'h0, 1'b1, 32'h500});
        adv();
        drain();

        // PC wraps at the top of the address space.
        idle();
        mem_addr_ok = 1;
        redirect0(32'hFFFF_FFFC);
        cyc();
        idle();
        eval();
        chk("wrap", 64'(rom_addr), 64'h0);
        adv();
        drain();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            redirect_valid[0] = ($urandom_range(0, 7) == 0);
            redirect_valid[1] = ($urandom_range(0, 7) == 0);
            redirect_addr     = {$urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC};
            fence_flush       = ($urandom_range(0, 9) == 0);
            jtag_halt_flag_i  = ($urandom_range(0, 19) == 0);
            clint_hold_flag   = ($urandom_range(0, 19) == 0);
            allow_in_if       = ($urandom_range(0, 9) != 0);
            mem_addr_ok       = ($urandom_range(0, 9) < 7);
            mem_data_ok       = ($urandom_range(0, 9) < 6);
            cyc();
        end

        // Async reset mid-stream.
        idle();
        mem_addr_ok = 1;
        cyc();
        rst_n = 0;
        model_reset();
        eval();
        chk("mid_rst", {rom_req, resp_valid, outstanding}, 4'h0);
        adv();
        rst_n = 1;
        idle();
        mem_addr_ok = 1;
        eval();
        chk("post_rst_pc", {31'h0, rom_req, rom_addr}, {31'h0, 1'b1, 32'h0});
        adv();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
